// File: rtl/spi_safety_regfile_pkg.sv
// Shared SPI command/register definitions for the safety-board register engine.
// Command codes stay 8-bit and are zero-extended to the configured word width.
package spi_safety_regfile_pkg;

  localparam int SPI_WORD_LENGTH = 8;

  typedef enum logic [7:0] {
    CMD_RD_CONT   = 8'h01,
    CMD_RD_FB     = 8'h02,
    CMD_RD_STATUS = 8'h03,
    CMD_RD_SHDN   = 8'h04,
    CMD_RD_CTRL   = 8'h05,
    CMD_WR_CONT   = 8'h81,
    CMD_WR_CTRL   = 8'h82,
    CMD_WR_SHDN   = 8'h83,
    CMD_WR_PG     = 8'h84
  } spi_cmd_t;

  // Status byte, MSB first, top-aligned in an 8-bit field.
  typedef struct packed {
    logic       fb_timeout_err;
    logic       invalid_req;
    logic [1:0] therm_sd;
    logic [3:0] rsvd;
  } status_reg_t;

  typedef struct packed {
    logic clr_err;
    logic reset_req;
  } control_reg_t;

  typedef struct packed {
    logic plus;
    logic minus;
  } contactor_data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IDX  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/spi_safety_regfile_fb_timeout_chan.sv
// One contactor channel's feedback-mismatch counter. expired_o flags the cycle on
// which the counter reaches (or sits at) FB_TIMEOUT while the mismatch persists.
module fb_timeout_chan
  import spi_safety_regfile_pkg::*;
#(
  parameter int FB_TIMEOUT = 1000,
  parameter int CNT_W      = $clog2(FB_TIMEOUT + 1)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic [1:0] cmd_i,
  input  logic [1:0] fb_i,
  output logic       expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FB_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch;

  assign mismatch = (cmd_i != fb_i);

  // Expiry is reported even when a clear lands on the same cycle so the sticky set wins.
  assign expired_o = mismatch && (cnt_q >= (LIMIT - CNT_W'(1)));

  always_comb begin
    if (clr_i || !mismatch) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_safety_regfile.sv
// SPI register/command engine: decodes {cmd, index, data} word frames, drives the
// contactor and shutdown outputs, and keeps sticky error flags with feedback timeouts.
module spi_safety_regfile
  import spi_safety_regfile_pkg::*;
#(
  parameter int WORD_W     = SPI_WORD_LENGTH,
  parameter int NUM_CONT   = 4,
  parameter int FB_TIMEOUT = 1000,
  parameter int CNT_W      = $clog2(FB_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  rx_valid,
  input  logic [WORD_W-1:0]     rx_data,
  output logic [WORD_W-1:0]     tx_data,
  output logic                  tx_load,
  input  logic [2*NUM_CONT-1:0] cont_fb,
  output logic [2*NUM_CONT-1:0] cont_cmd,
  input  logic [1:0]            therm_sd,
  output logic                  shutdown,
  output logic                  pg_shutdown,
  output logic                  soft_reset,
  output logic                  irq
);

  fsm_state_t            state_q;
  logic [WORD_W-1:0]     cmd_q, idx_q, tx_data_q;
  logic                  tx_load_q, shutdown_q, pg_q, soft_reset_q;
  logic                  fb_err_q, inv_q, irq_q;
  logic [2*NUM_CONT-1:0] cont_cmd_q, cont_cmd_d;
  logic                  fb_err_d, inv_d;

  logic                  rd_cont, rd_fb, rd_stat, rd_shdn, rd_ctrl;
  logic                  wr_cont, wr_ctrl, wr_shdn, wr_pg;
  logic                  idx_fire, data_fire, idx_ok, req_bad, rsp_valid, clr_all;
  logic [WORD_W-1:0]     rsp;
  contactor_data_t       sel_cmd, sel_fb;
  status_reg_t           status_s;
  control_reg_t          ctrl_s;
  logic [NUM_CONT-1:0]   wr_hit, cnt_clr, expired;

  assign rd_cont = (cmd_q == WORD_W'(CMD_RD_CONT));
  assign rd_fb   = (cmd_q == WORD_W'(CMD_RD_FB));
  assign rd_stat = (cmd_q == WORD_W'(CMD_RD_STATUS));
  assign rd_shdn = (cmd_q == WORD_W'(CMD_RD_SHDN));
  assign rd_ctrl = (cmd_q == WORD_W'(CMD_RD_CTRL));
  assign wr_cont = (cmd_q == WORD_W'(CMD_WR_CONT));
  assign wr_ctrl = (cmd_q == WORD_W'(CMD_WR_CTRL));
  assign wr_shdn = (cmd_q == WORD_W'(CMD_WR_SHDN));
  assign wr_pg   = (cmd_q == WORD_W'(CMD_WR_PG));

  // Cs_n high masks every strobe so an aborted frame has no side effects.
  assign idx_fire  = (state_q == ST_IDX)  && rx_valid && !cs_n;
  assign data_fire = (state_q == ST_DATA) && rx_valid && !cs_n;
  assign ctrl_s    = control_reg_t'(rx_data[1:0]);
  assign clr_all   = data_fire && wr_ctrl && ctrl_s.clr_err;

  // Read response and request validation, evaluated against the index word on the wire.
  always_comb begin
    sel_cmd = '0;
    sel_fb  = '0;
    for (int i = 0; i < NUM_CONT; i++) begin
      sel_cmd = (rx_data == WORD_W'(i)) ? contactor_data_t'(cont_cmd_q[2*i +: 2]) : sel_cmd;
      sel_fb  = (rx_data == WORD_W'(i)) ? contactor_data_t'(cont_fb[2*i +: 2])    : sel_fb;
    end
    status_s.fb_timeout_err = fb_err_q;
    status_s.invalid_req    = inv_q;
    status_s.therm_sd       = therm_sd;
    status_s.rsvd           = 4'b0000;
    idx_ok    = (rx_data < WORD_W'(NUM_CONT));
    rsp       = '0;
    rsp_valid = 1'b0;
    req_bad   = 1'b0;
    if (rd_cont) begin
      rsp_valid = 1'b1;
      rsp       = idx_ok ? WORD_W'(sel_cmd) : '0;
      req_bad   = !idx_ok;
    end else if (rd_fb) begin
      rsp_valid = 1'b1;
      rsp       = idx_ok ? WORD_W'(sel_fb) : '0;
      req_bad   = !idx_ok;
    end else if (rd_stat) begin
      rsp_valid = 1'b1;
      rsp       = WORD_W'(status_s);
    end else if (rd_shdn) begin
      rsp_valid = 1'b1;
      rsp       = WORD_W'({pg_q, shutdown_q});
    end else if (rd_ctrl) begin
      rsp_valid = 1'b1;
    end else if (wr_cont) begin
      req_bad = !idx_ok;
    end else if (wr_ctrl || wr_shdn || wr_pg) begin
      req_bad = 1'b0;
    end else begin
      req_bad = 1'b1;
    end
  end

  // Contactor write decode and sticky flag next-state; out-of-range indices hit no channel.
  always_comb begin
    for (int i = 0; i < NUM_CONT; i++) begin
      wr_hit[i]               = data_fire && wr_cont && (idx_q == WORD_W'(i));
      cont_cmd_d[2*i +: 2]    = wr_hit[i] ? rx_data[1:0] : cont_cmd_q[2*i +: 2];
      cnt_clr[i]              = wr_hit[i] | clr_all;
    end
    fb_err_d = (fb_err_q & ~clr_all) | (|expired);
    inv_d    = (inv_q & ~clr_all) | (idx_fire & req_bad);
  end

  for (genvar g = 0; g < NUM_CONT; g++) begin : g_chan
    fb_timeout_chan #(
      .FB_TIMEOUT (FB_TIMEOUT),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clr_i     (cnt_clr[g]),
      .cmd_i     (cont_cmd_q[2*g +: 2]),
      .fb_i      (cont_fb[2*g +: 2]),
      .expired_o (expired[g])
    );
  end

  // Frame FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      idx_q        <= '0;
      tx_data_q    <= '0;
      tx_load_q    <= 1'b0;
      cont_cmd_q   <= '0;
      shutdown_q   <= 1'b0;
      pg_q         <= 1'b0;
      soft_reset_q <= 1'b0;
      fb_err_q     <= 1'b0;
      inv_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      tx_load_q    <= 1'b0;
      soft_reset_q <= 1'b0;
      cont_cmd_q   <= cont_cmd_d;
      fb_err_q     <= fb_err_d;
      inv_q        <= inv_d;
      irq_q        <= fb_err_d | inv_d;
      if (cs_n) begin
        state_q   <= ST_IDLE;
        tx_data_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_valid) begin
              cmd_q   <= rx_data;
              state_q <= ST_IDX;
            end
          end
          ST_IDX: begin
            if (rx_valid) begin
              idx_q     <= rx_data;
              state_q   <= ST_DATA;
              tx_load_q <= rsp_valid;
              tx_data_q <= rsp;
            end
          end
          ST_DATA: begin
            if (rx_valid) begin
              state_q   <= ST_DONE;
              tx_data_q <= '0;
              if (wr_shdn) shutdown_q <= rx_data[0];
              if (wr_pg) pg_q <= rx_data[0];
              if (wr_ctrl) soft_reset_q <= ctrl_s.reset_req;
            end
          end
          ST_DONE: begin
            tx_data_q <= '0;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_load     = tx_load_q;
  assign cont_cmd    = cont_cmd_q;
  assign shutdown    = shutdown_q;
  assign pg_shutdown = pg_q;
  assign soft_reset  = soft_reset_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_spi_safety_regfile.sv
// Directed bench: read responses go through an expected-value queue checked by a
// negedge monitor on tx_load; register outputs are checked directly at quiet points.
module tb_spi_safety_regfile;

  localparam int WORD_W     = 8;
  localparam int NUM_CONT   = 4;
  localparam int FB_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, rx_valid;
  logic [7:0] rx_data, tx_data;
  logic       tx_load;
  logic [7:0] cont_fb, cont_cmd;
  logic [1:0] therm_sd;
  logic       shutdown, pg_shutdown, soft_reset, irq;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  spi_safety_regfile #(
    .WORD_W     (WORD_W),
    .NUM_CONT   (NUM_CONT),
    .FB_TIMEOUT (FB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_n        (cs_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .cont_fb     (cont_fb),
    .cont_cmd    (cont_cmd),
    .therm_sd    (therm_sd),
    .shutdown    (shutdown),
    .pg_shutdown (pg_shutdown),
    .soft_reset  (soft_reset),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every tx_load must match the oldest expected response and cycle.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    int         c;
    if (tx_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: tx_load with tx_data %0h, expected no load", tx_data);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("sb_data", tx_data, e);
        chk("sb_latency", cyc, c);
      end
    end
  end

  task automatic word(input logic [7:0] w);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = w;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic rd_word(input logic [7:0] idx, input logic [7:0] exp);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = idx;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr_frame(input logic [7:0] c, input logic [7:0] i, input logic [7:0] d);
    cs_low();
    word(c);
    word(i);
    word(d);
    cs_high();
  endtask

  task automatic rd_frame(input logic [7:0] c, input logic [7:0] i, input logic [7:0] exp);
    cs_low();
    word(c);
    rd_word(i, exp);
    word(8'h00);
    cs_high();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cont_cmd"}, cont_cmd, 8'h00);
    chk({tag, "_shutdown"}, shutdown, 1'b0);
    chk({tag, "_pg"}, pg_shutdown, 1'b0);
    chk({tag, "_soft_reset"}, soft_reset, 1'b0);
    chk({tag, "_irq"}, irq, 1'b0);
    chk({tag, "_tx_load"}, tx_load, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
  endtask

  initial begin
    rst_n    = 1'b0;
    cs_n     = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cont_fb  = 8'h00;
    therm_sd = 2'b00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Contactor write and readback
    wr_frame(8'h81, 8'h02, 8'h03);
    cont_fb = 8'h30;
    chk("wr_cont", cont_cmd, 8'h30);
    rd_frame(8'h01, 8'h02, 8'h03);
    rd_frame(8'h02, 8'h02, 8'h03);
    rd_frame(8'h01, 8'h01, 8'h00);

    // Out-of-range index
    chk("irq_idle", irq, 1'b0);
    wr_frame(8'h81, 8'h07, 8'h01);
    chk("bad_idx_drop", cont_cmd, 8'h30);
    chk("bad_idx_irq", irq, 1'b1);
    rd_frame(8'h03, 8'h00, 8'h40);
    rd_frame(8'h01, 8'h05, 8'h00);
    rd_frame(8'h04, 8'h00, 8'h00);
    rd_frame(8'h05, 8'h00, 8'h00);

    // Clear, thermal mirror, unknown command
    wr_frame(8'h82, 8'h00, 8'h02);
    chk("clr_irq", irq, 1'b0);
    rd_frame(8'h03, 8'h00, 8'h00);
    therm_sd = 2'b10;
    rd_frame(8'h03, 8'h00, 8'h20);
    therm_sd = 2'b00;
    wr_frame(8'h55, 8'h00, 8'h00);
    chk("unknown_irq", irq, 1'b1);
    rd_frame(8'h03, 8'h00, 8'h40);
    wr_frame(8'h82, 8'h00, 8'h02);
    chk("clr2_irq", irq, 1'b0);

    // Near-miss: mismatch lasts FB_TIMEOUT-1 cycles, then feedback agrees
    cs_low();
    word(8'h81);
    word(8'h00);
    word(8'h01);
    repeat (FB_TIMEOUT - 1) @(negedge clk);
    chk("tmo_near", irq, 1'b0);
    cont_fb = 8'h31;
    repeat (3) @(negedge clk);
    chk("tmo_near_after", irq, 1'b0);
    cs_high();
    rd_frame(8'h03, 8'h00, 8'h00);

    // Exact expiry after FB_TIMEOUT mismatched cycles
    cont_fb = 8'h30;
    repeat (FB_TIMEOUT - 1) @(negedge clk);
    chk("tmo_minus1", irq, 1'b0);
    @(negedge clk);
    chk("tmo_exact", irq, 1'b1);
    rd_frame(8'h03, 8'h00, 8'h80);
    wr_frame(8'h81, 8'h07, 8'h01);
    rd_frame(8'h03, 8'h00, 8'hC0);
    wr_frame(8'h82, 8'h00, 8'h02);
    chk("set_wins_irq", irq, 1'b1);
    rd_frame(8'h03, 8'h00, 8'h80);
    cont_fb = 8'h31;
    wr_frame(8'h82, 8'h00, 8'h02);
    chk("clr_both_irq", irq, 1'b0);
    rd_frame(8'h03, 8'h00, 8'h00);

    // Soft reset pulse
    cs_low();
    word(8'h82);
    word(8'h00);
    word(8'h01);
    chk("soft_reset_hi", soft_reset, 1'b1);
    @(negedge clk);
    chk("soft_reset_lo", soft_reset, 1'b0);
    cs_high();

    // Abort before data word, then next frames decode from IDLE
    cs_low();
    word(8'h83);
    word(8'h00);
    cs_high();
    chk("abort_shdn", shutdown, 1'b0);
    rd_frame(8'h04, 8'h00, 8'h00);
    wr_frame(8'h83, 8'h00, 8'h01);
    chk("shdn_set", shutdown, 1'b1);

    // Data word coinciding with cs_n rising: abort wins
    cs_low();
    word(8'h84);
    word(8'h00);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    cs_n     = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    chk("abort_same_cycle_pg", pg_shutdown, 1'b0);
    wr_frame(8'h84, 8'h00, 8'h01);
    chk("pg_set", pg_shutdown, 1'b1);
    rd_frame(8'h04, 8'h00, 8'h03);

    // Words in DONE are ignored
    cs_low();
    word(8'h83);
    word(8'h00);
    word(8'h00);
    word(8'h01);
    cs_high();
    chk("done_ignore", shutdown, 1'b0);

    // Reset mid-frame after the index word of a write
    wr_frame(8'h81, 8'h07, 8'h00);
    chk("pre_rst_irq", irq, 1'b1);
    cs_low();
    word(8'h81);
    word(8'h01);
    @(negedge clk);
    rst_n   = 1'b0;
    cont_fb = 8'h00;
    @(negedge clk);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    cs_n  = 1'b1;
    @(negedge clk);
    wr_frame(8'h81, 8'h01, 8'h02);
    cont_fb = 8'h08;
    chk("post_rst_wr", cont_cmd, 8'h08);
    rd_frame(8'h01, 8'h01, 8'h02);
    rd_frame(8'h03, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
